// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one single-port synchronous memory.
// ARB_RR_EN selects round-robin; default is fixed data-over-fetch.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CW = $clog2(WAIT_CYC + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          win_d;
  logic          grant_d;

`ifdef ARB_RR_EN
  logic last_d;

  // On a collision the side not granted last time wins.
  assign grant_d = d_req & (~if_req | ~last_d);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      win_d     <= 1'b0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
`ifdef ARB_RR_EN
      last_d    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (if_req | d_req) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            mem_cs    <= 1'b1;
            win_d     <= grant_d;
            mem_we    <= grant_d & d_we;
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_wdata <= d_wdata;
            cnt       <= CNT_INIT;
`ifdef ARB_RR_EN
            last_d    <= grant_d;
`endif
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state  <= DONE;
            mem_cs <= 1'b0;
            mem_we <= 1'b0;
            if (win_d) begin
              d_ack <= 1'b1;
              if (!mem_we)
                d_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a transaction-level model.
// Honours ARB_RR_EN the same way the design does.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 2;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem_arr [128];
  bit            wr_vld  [128];
  logic [DW-1:0] ref_mem [128];
  logic [DW-1:0] exp_if_rdata;
  logic [DW-1:0] exp_d_rdata;
  bit            ref_last;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(W)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] init_val(input logic [6:0] i);
    if (i == 7'd16)
      return 32'h00A0_0093;
    return 32'h1357_0000 ^ ({25'd0, i} * 32'h9E37_79B9);
  endfunction

  assign mem_rdata = wr_vld[mem_addr[8:2]] ?
                     mem_arr[mem_addr[8:2]] :
                     init_val(mem_addr[8:2]);

  always @(posedge clk)
    if (mem_cs && mem_we) begin
      mem_arr[mem_addr[8:2]] <= mem_wdata;
      wr_vld[mem_addr[8:2]]  <= 1'b1;
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  // One request set issued from IDLE; checks every cycle until idle again.
  task automatic run_txn(input bit fr, input bit dr, input bit we,
                         input logic [AW-1:0] fa, input logic [AW-1:0] da,
                         input logic [DW-1:0] wd, input bit drop);
    bit first_d, both, cur_d, e_cs, e_ia, e_da, e_busy;
    int ack1, ack2, last_c;
    logic [DW-1:0] v;
    both = fr & dr;
    if (both)
      first_d = RR ? !ref_last : 1'b1;
    else
      first_d = dr;
    ref_last = both ? !first_d : first_d;
    ack1   = W + 1;
    ack2   = 2 * W + 3;
    last_c = both ? ack2 + 1 : ack1 + 1;
    if_req = fr; if_addr = fa;
    d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
    for (int c = 1; c <= last_c; c++) begin
      tick();
      e_cs   = (c <= W) || (both && c >= W + 3 && c <= 2 * W + 2);
      e_busy = (c <= ack1) || (both && c >= W + 3 && c <= ack2);
      cur_d  = (c <= ack1) ? first_d : !first_d;
      e_ia   = (c == ack1 && !first_d) || (both && c == ack2 && first_d);
      e_da   = (c == ack1 && first_d) || (both && c == ack2 && !first_d);
      checks += 4;
      if (mem_cs !== e_cs) begin
        errors++;
        $display("FAIL mem_cs c=%0d got=%b exp=%b", c, mem_cs, e_cs);
      end
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL busy c=%0d got=%b exp=%b", c, busy, e_busy);
      end
      if (if_ack !== e_ia) begin
        errors++;
        $display("FAIL if_ack c=%0d got=%b exp=%b", c, if_ack, e_ia);
      end
      if (d_ack !== e_da) begin
        errors++;
        $display("FAIL d_ack c=%0d got=%b exp=%b", c, d_ack, e_da);
      end
      if (e_cs) begin
        checks += 2;
        if (mem_addr !== (cur_d ? da : fa)) begin
          errors++;
          $display("FAIL mem_addr c=%0d got=%h exp=%h",
                   c, mem_addr, cur_d ? da : fa);
        end
        if (mem_we !== (cur_d & we)) begin
          errors++;
          $display("FAIL mem_we c=%0d got=%b exp=%b",
                   c, mem_we, cur_d & we);
        end
      end
      if (e_ia) begin
        exp_if_rdata = ref_mem[fa[8:2]];
        checks += 2;
        if (if_rdata !== exp_if_rdata) begin
          errors++;
          $display("FAIL if_rdata got=%h exp=%h", if_rdata, exp_if_rdata);
        end
        if (d_rdata !== exp_d_rdata) begin
          errors++;
          $display("FAIL d_rdata_hold got=%h exp=%h", d_rdata, exp_d_rdata);
        end
        if_req = 1'b0;
      end
      if (e_da) begin
        if (we)
          ref_mem[da[8:2]] = wd;
        else
          exp_d_rdata = ref_mem[da[8:2]];
        checks += 2;
        if (d_rdata !== exp_d_rdata) begin
          errors++;
          $display("FAIL d_rdata got=%h exp=%h", d_rdata, exp_d_rdata);
        end
        if (if_rdata !== exp_if_rdata) begin
          errors++;
          $display("FAIL if_rdata_hold got=%h exp=%h", if_rdata, exp_if_rdata);
        end
        d_req = 1'b0;
      end
      if (drop && c == 1) begin
        v = $urandom & 32'hFFFF_FFFC;
        if (first_d) begin
          d_req = 1'b0; d_addr = v; d_wdata = ~v;
        end else begin
          if_req = 1'b0; if_addr = v;
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if_req = 1'($urandom); if_addr = $urandom;
      d_req = 1'($urandom); d_we = 1'($urandom);
      d_addr = $urandom; d_wdata = $urandom;
      tick();
      checks += 3;
      if ({if_ack, d_ack, mem_cs, mem_we, busy} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctl got=%b exp=00000",
                 {if_ack, d_ack, mem_cs, mem_we, busy});
      end
      if ({if_rdata, d_rdata} !== 64'd0) begin
        errors++;
        $display("FAIL reset_rdata got=%h/%h exp=0", if_rdata, d_rdata);
      end
      if ({mem_addr, mem_wdata} !== 64'd0) begin
        errors++;
        $display("FAIL reset_mem got=%h/%h exp=0", mem_addr, mem_wdata);
      end
    end
    idle_inputs();
    rst = 1'b1;
    ref_last = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata = '0;
    tick();
  endtask

  task automatic test_fetch_alone();
    run_txn(1'b1, 1'b0, 1'b0, 32'h40, '0, '0, 1'b0);
    checks++;
    if (if_rdata !== 32'h00A0_0093) begin
      errors++;
      $display("FAIL fetch_data got=%h exp=00a00093", if_rdata);
    end
  endtask

  task automatic test_store();
    run_txn(1'b0, 1'b1, 1'b1, '0, 32'h100, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (mem_arr[64] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL store_mem got=%h exp=deadbeef", mem_arr[64]);
    end
    run_txn(1'b0, 1'b1, 1'b0, '0, 32'h100, '0, 1'b0);
    checks++;
    if (d_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL load_back got=%h exp=deadbeef", d_rdata);
    end
  endtask

  task automatic test_collision();
    run_txn(1'b1, 1'b1, 1'b0, 32'h40, 32'h100, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_txn(1'b1, 1'b1, 1'(i), 32'h40 + 32'(4 * i),
              32'h200 + 32'(4 * i), 32'hA5A5_0000 + 32'(i), 1'b0);
  endtask

  task automatic test_mid_reset();
    if_req = 1'b1; if_addr = 32'h80;
    tick();
    tick();
    checks++;
    if (mem_cs !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_cs got=%b exp=1", mem_cs);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_cs, busy} !== 2'b00) begin
      errors++;
      $display("FAIL mid_async got=%b exp=00", {mem_cs, busy});
    end
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({if_ack, d_ack, mem_cs} !== 3'b000) begin
        errors++;
        $display("FAIL mid_noack got=%b exp=000", {if_ack, d_ack, mem_cs});
      end
    end
    rst = 1'b1;
    ref_last = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata = '0;
    tick();
    run_txn(1'b1, 1'b0, 1'b0, 32'h80, '0, '0, 1'b0);
  endtask

  task automatic test_random();
    bit fr, dr;
    for (int i = 0; i < 60; i++) begin
      fr = 1'($urandom);
      dr = 1'($urandom);
      if (!fr && !dr)
        fr = 1'b1;
      run_txn(fr, dr, 1'($urandom),
              $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
              $urandom, ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 128; i++)
      ref_mem[i] = init_val(7'(i));
    test_reset();
    test_fetch_alone();
    test_store();
    test_collision();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
